// File: rtl/word_split.sv
// word_split: breaks 32-bit words into two 16-bit halfwords, valid/ready both sides.
// Ports: clk, reset_n | in_valid/in_ready/in_word | flush | out_valid/out_ready/out_half/out_upper/out_last | word_cnt
module word_split #(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_half,
  output logic        out_upper,
  output logic        out_last,
  output logic [7:0]  word_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND
  } state_e;

  state_e      state_q;
  logic        valid_q;
  logic [15:0] half_q;
  logic [15:0] sec_q;
  logic        upper_q;
  logic        last_q;
  logic [7:0]  cnt_q;
  logic        in_hs;

  assign in_ready = ((state_q == IDLE) ||
                     ((state_q == SECOND) && out_ready))
                    && !flush;
  assign in_hs    = in_valid && in_ready;

  assign out_valid = valid_q;
  assign out_half  = half_q;
  assign out_upper = upper_q;
  assign out_last  = last_q;
  assign word_cnt  = cnt_q;

  // The half not shown first is parked in sec_q so the
  // output registers never see in_word combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      half_q  <= 16'h0000;
      sec_q   <= 16'h0000;
      upper_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= 8'h00;
    end else if (flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_hs) begin
            state_q <= FIRST;
            valid_q <= 1'b1;
            half_q  <= HI_FIRST ? in_word[31:16]
                                : in_word[15:0];
            sec_q   <= HI_FIRST ? in_word[15:0]
                                : in_word[31:16];
            upper_q <= HI_FIRST;
            last_q  <= 1'b0;
          end
        end
        FIRST: begin
          if (out_ready) begin
            state_q <= SECOND;
            half_q  <= sec_q;
            upper_q <= !HI_FIRST;
            last_q  <= 1'b1;
          end
        end
        SECOND: begin
          if (out_ready) begin
            cnt_q <= cnt_q + 8'd1;
            if (in_hs) begin
              state_q <= FIRST;
              half_q  <= HI_FIRST ? in_word[31:16]
                                  : in_word[15:0];
              sec_q   <= HI_FIRST ? in_word[15:0]
                                  : in_word[31:16];
              upper_q <= HI_FIRST;
              last_q  <= 1'b0;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/word_split.md
WORD_SPLIT -- requirements
Module: word_split

Interface
REQ-001 Parameter HI_FIRST, default 1, SHALL select halfword order: 1 = upper half {word[31:16]} first, 0 = lower half {word[15:0]} first.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream holds a 32-bit word.
REQ-005 in_ready  output  1  block accepts in_word this cycle.
REQ-006 in_word  input  32  word to split.
REQ-007 flush  input  1  synchronous abort of the word in progress.
REQ-008 out_valid  output  1  out_half holds a valid halfword.
REQ-009 out_ready  input  1  downstream accepts out_half this cycle.
REQ-010 out_half  output  16  current halfword.
REQ-011 out_upper  output  1  1 when out_half is word[31:16], 0 when word[15:0].
REQ-012 out_last  output  1  1 on the second halfword of a word.
REQ-013 word_cnt  output  8  count of fully emitted words.

Function
REQ-014 Input handshake SHALL complete when in_valid and in_ready are both 1 at a rising edge; output handshake when out_valid and out_ready are both 1.
REQ-015 FSM SHALL have states IDLE, FIRST, SECOND; out_valid SHALL be 1 exactly in FIRST and SECOND.
REQ-016 IDLE -> FIRST on input handshake; FIRST -> SECOND on output handshake; SECOND -> FIRST on output handshake with simultaneous input handshake; SECOND -> IDLE on output handshake without input handshake.
REQ-017 in_ready SHALL be combinational: 1 when (state = IDLE or (state = SECOND and out_ready = 1)) and flush = 0, else 0.
REQ-018 Accepted word SHALL be registered internally; out_half, out_upper, out_last SHALL be driven from registered state only (no combinational path from in_word).
REQ-019 Latency: word accepted at edge N SHALL present its first halfword with out_valid = 1 in the cycle after edge N.
REQ-020 Sustained throughput SHALL be one word per two cycles with out_ready held 1 and in_valid held 1; no idle bubble between words.
REQ-021 While out_valid = 1 and out_ready = 0, out_half, out_upper, out_last SHALL hold stable.
REQ-022 In FIRST, out_last SHALL be 0 and out_upper SHALL equal HI_FIRST; in SECOND, out_last SHALL be 1 and out_upper SHALL equal not HI_FIRST.
REQ-023 word_cnt SHALL increment by 1 on every output handshake in SECOND, wrapping 255 -> 0.
REQ-024 flush = 1 SHALL force the next state to IDLE, discard the held word, block any input handshake that cycle, and leave word_cnt unchanged, even if an output handshake occurs that cycle.
REQ-025 In IDLE, out_half SHALL hold its last value; its content is don't-care while out_valid = 0.

Reset
REQ-026 reset_n = 0 SHALL immediately and asynchronously force state IDLE, out_valid 0, out_half 16'h0000, out_upper 0, out_last 0, word_cnt 8'h00.
REQ-027 Reset asserted mid-word SHALL drop that word without emitting its remaining halfword.
REQ-028 After reset_n deasserts, in_ready SHALL be 1 in the first cycle (flush = 0).

Verification
REQ-029 HI_FIRST=1, in_word 32'hDEAD_BEEF, out_ready=1 -> out_half 16'hDEAD (upper=1,last=0) next cycle, then 16'hBEEF (upper=0,last=1), word_cnt = 1.
REQ-030 HI_FIRST=0, same word -> 16'hBEEF first (upper=0), then 16'hDEAD (upper=1,last=1).
REQ-031 Back-to-back words 32'h1111_2222, 32'h3333_4444, out_ready=1 -> halfwords 1111,2222,3333,4444 on four consecutive cycles, in_ready=1 in the SECOND cycles, word_cnt = 2.
REQ-032 out_ready=0 for 3 cycles during FIRST of 32'hCAFE_F00D -> out_half holds 16'hCAFE stable, in_ready=0, no state change.
REQ-033 flush=1 in SECOND with in_valid=1 -> next cycle IDLE, out_valid=0, word not accepted, word_cnt unchanged; reset_n pulsed low mid-word -> all outputs at reset values asynchronously.
REQ-034 256 complete words -> word_cnt wraps to 8'h00.
